// File: rtl/load_store_unit_if.sv
// Core/memory-side signal bundle for the load/store unit.
// The slave view belongs to the unit; the master view is the core plus data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store initiator for a word-addressed data memory,
// with sub-word loads (sign/zero extend), read-modify-write sub-word stores and error checks.
module load_store_unit #(
  parameter int MEM_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic        r_err;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_wword;
  logic        w_accept;
  logic        w_err;
  logic        w_rd;
  logic        w_wr;
  logic        w_rsp;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic bad;
    case (f3)
      3'd0:    bad = 1'b0;
      3'd1:    bad = a[0];
      3'd2:    bad = (a[1:0] != 2'b00);
      3'd4:    bad = we;
      3'd5:    bad = we | a[0];
      default: bad = 1'b1;
    endcase
    if (a >= ADDR_LIMIT) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    res = 32'(b);
      3'd1:    res = 32'(h);
      3'd4:    res = {24'h0, b};
      3'd5:    res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word, input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    if (f3[1:0] == 2'd0) res[{lo, 3'b000} +: 8] = wdata[7:0];
    else                 res[{lo[1], 4'b0000} +: 16] = wdata[15:0];
    return res;
  endfunction

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_err    = req_error(bus.req_we, bus.req_funct3, bus.req_addr);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_err)                     w_next = RESP;
          else if (!bus.req_we)          w_next = LOAD;
          else if (bus.req_funct3 == 3'd2) w_next = WRITE;
          else                           w_next = RMW_RD;
        end
      end
      LOAD:    w_next = RESP;
      RMW_RD:  w_next = WRITE;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Accept stage: latch the request; later stages fill in load data or the merged store word
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_err   <= w_err;
      r_f3    <= bus.req_funct3;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_rdata <= '0;
      r_wword <= bus.req_wdata;
    end
    if (r_state == LOAD)   r_rdata <= load_extend(r_f3, r_addr[1:0], bus.mem_rdata);
    if (r_state == RMW_RD) r_wword <= store_merge(r_f3, r_addr[1:0], bus.mem_rdata, r_wdata);
  end

  // Outputs are forced to reset values during the reset cycle so an aborted write never lands
  assign w_rd  = !rst && ((r_state == LOAD) || (r_state == RMW_RD));
  assign w_wr  = !rst && (r_state == WRITE);
  assign w_rsp = !rst && (r_state == RESP);

  assign bus.req_ready = rst || (r_state == IDLE);
  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_rdata = w_rsp ? r_rdata : '0;
  assign bus.rsp_err   = w_rsp & r_err;
  assign bus.mem_read  = w_rd;
  assign bus.mem_write = w_wr;
  assign bus.mem_addr  = (w_rd || w_wr) ? {2'b00, r_addr[31:2]} : '0;
  assign bus.mem_wdata = w_wr ? r_wword : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequences and random traffic
// checked against a byte-array memory model, plus per-cycle bus invariants.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit #(.MEM_DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0]  mem [64];
  byte unsigned ref_b [256];
  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rsp_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_rsp = 1'b0;

  assign bus.mem_rdata = (bus.mem_addr < 32'd64) ? mem[bus.mem_addr[5:0]] : 32'h0;

  always @(posedge clk)
    if (bus.mem_write === 1'b1 && bus.mem_addr < 32'd64) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;

  // Per-cycle protocol invariants, sampled well after the falling edge
  always @(negedge clk) begin : monitor
    bit bad;
    #2;
    if (mon_en) begin
      bad = $isunknown({bus.req_ready, bus.rsp_valid, bus.mem_read, bus.mem_write})
         || (bus.mem_read && bus.mem_write)
         || (bus.req_ready && (bus.rsp_valid || bus.mem_read || bus.mem_write))
         || (prev_rsp && bus.rsp_valid)
         || (!bus.rsp_valid && (bus.rsp_rdata != 32'h0 || bus.rsp_err))
         || (!bus.mem_read && !bus.mem_write && (bus.mem_addr != 32'h0 || bus.mem_wdata != 32'h0))
         || ((bus.mem_read || bus.mem_write) && bus.mem_addr >= 32'd64);
      n_cmp++;
      if (bad) begin
        n_fail++;
        $display("FAIL invariant t=%0t: rdy=%b rv=%b rd=%b wr=%b addr=%0h wd=%0h rdata=%0h err=%b prev_rv=%b (required: legal bus state)",
                 $time, bus.req_ready, bus.rsp_valid, bus.mem_read, bus.mem_write, bus.mem_addr,
                 bus.mem_wdata, bus.rsp_rdata, bus.rsp_err, prev_rsp);
      end
      rd_cnt  += int'(bus.mem_read);
      wr_cnt  += int'(bus.mem_write);
      rsp_cnt += int'(bus.rsp_valid);
      prev_rsp = bus.rsp_valid;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and plain arithmetic
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    if (a % m_size(f3) != 0) return 1'b1;
    if (a >= 32'd256) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int sz = m_size(f3);
    for (int i = 0; i < sz; i++) v += longint'(ref_b[a + i]) << (8 * i);
    if (f3 < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < m_size(f3); i++) ref_b[a + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] m_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // One transaction; request inputs are scrambled while busy to show they are ignored
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr, wdata,
                         output logic [31:0] rdata, output bit err, output int lat,
                         output int nrd, output int nwr);
    int rd0, wr0;
    bit got;
    @(negedge clk);
    check("req_ready_before_req", 128'(bus.req_ready), 128'(1));
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 0; got = 1'b0; rdata = '0; err = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end
    end
    bus.req_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no rsp_valid within 10 cycles (required: response)");
      lat = -1;
    end
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  task automatic exec(input string name, input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, wdata, exp_rdata, input bit exp_err,
                      input int exp_lat);
    logic [31:0] rd;
    bit er;
    int lat, nrd, nwr, erd, ewr;
    run_req(we, f3, addr, wdata, rd, er, lat, nrd, nwr);
    erd = (exp_err || (we && f3 == 3'd2)) ? 0 : 1;
    ewr = (exp_err || !we) ? 0 : 1;
    check({name, ".rdata"}, 128'(rd), 128'(exp_rdata));
    check({name, ".err"}, 128'(er), 128'(exp_err));
    check({name, ".latency"}, 128'(lat), 128'(exp_lat));
    check({name, ".mem_rd_wr_cycles"}, 128'({nrd, nwr}), 128'({erd, ewr}));
    if (we && !exp_err) m_store(f3, addr, wdata);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write,
                 bus.rsp_rdata, bus.mem_addr, bus.mem_wdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
  endtask

  // Reset lands 'cyc' falling edges after acceptance of a store
  task automatic reset_abort(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int cyc);
    int wr0, rs0;
    @(negedge clk);
    wr0 = wr_cnt; rs0 = rsp_cnt;
    bus.req_we = 1'b1; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs({name, ".outputs_in_reset"});
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs({name, ".outputs_after_reset"});
    repeat (6) @(negedge clk);
    check({name, ".no_write_no_rsp"}, 128'({wr_cnt - wr0, rsp_cnt - rs0}), 128'({32'd0, 32'd0}));
    check({name, ".mem_word"}, 128'(mem[addr[7:2]]), 128'(m_word(int'(addr[7:2]))));
  endtask

  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    vecs[0]  = '{"sw_10",    1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2};
    vecs[1]  = '{"lw_10",    1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{"sb_11",    1'b1, 3'd0, 32'h11,  32'h0000007F, 32'h0,        1'b0, 3};
    vecs[3]  = '{"lw_10b",   1'b0, 3'd2, 32'h10,  32'h0,        32'hDEAD7FEF, 1'b0, 2};
    vecs[4]  = '{"lb_11",    1'b0, 3'd0, 32'h11,  32'h0,        32'h0000007F, 1'b0, 2};
    vecs[5]  = '{"lb_13",    1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 2};
    vecs[6]  = '{"lbu_13",   1'b0, 3'd4, 32'h13,  32'h0,        32'h000000DE, 1'b0, 2};
    vecs[7]  = '{"sh_22",    1'b1, 3'd1, 32'h22,  32'hFFFF8001, 32'h0,        1'b0, 3};
    vecs[8]  = '{"lw_20",    1'b0, 3'd2, 32'h20,  32'h0,        32'h80010000, 1'b0, 2};
    vecs[9]  = '{"lh_22",    1'b0, 3'd1, 32'h22,  32'h0,        32'hFFFF8001, 1'b0, 2};
    vecs[10] = '{"lhu_22",   1'b0, 3'd5, 32'h22,  32'h0,        32'h00008001, 1'b0, 2};
    vecs[11] = '{"lw_06",    1'b0, 3'd2, 32'h06,  32'h0,        32'h0,        1'b1, 1};
    vecs[12] = '{"sh_03",    1'b1, 3'd1, 32'h03,  32'h1234,     32'h0,        1'b1, 1};
    vecs[13] = '{"lb_100",   1'b0, 3'd0, 32'h100, 32'h0,        32'h0,        1'b1, 1};
    vecs[14] = '{"f3_3",     1'b0, 3'd3, 32'h0,   32'h0,        32'h0,        1'b1, 1};
    vecs[15] = '{"sb_ff",    1'b1, 3'd0, 32'hFF,  32'h123456AB, 32'h0,        1'b0, 3};
    vecs[16] = '{"lw_fc",    1'b0, 3'd2, 32'hFC,  32'h0,        32'hAB000000, 1'b0, 2};
    vecs[17] = '{"lh_fe",    1'b0, 3'd1, 32'hFE,  32'h0,        32'hFFFFAB00, 1'b0, 2};
    vecs[18] = '{"sw_100",   1'b1, 3'd2, 32'h100, 32'h55,       32'h0,        1'b1, 1};
    vecs[19] = '{"sb_lbu_f3",1'b1, 3'd4, 32'h08,  32'h55,       32'h0,        1'b1, 1};

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset_during");
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("reset_idle");
    mon_en = 1'b1;

    foreach (vecs[i])
      exec(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);

    reset_abort("rst_in_rmw_sb", 3'd0, 32'h41, 32'h55, 1);
    reset_abort("rst_in_write_sw", 3'd2, 32'h44, 32'h12345678, 1);
    reset_abort("rst_in_write_sh", 3'd1, 32'h4A, 32'hBEEF, 2);
    exec("after_reset_lw_40", 1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 1'b0, 2);

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      logic [2:0]  f3;
      logic [31:0] addr, wd, exp_rd;
      bit          we, er;
      int          r, lat;
      logic [2:0]  f3_tab [10];
      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
      f3 = f3_tab[$urandom_range(0, 9)];
      we = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) addr = $urandom;
      else        addr = $urandom_range(0, 263);
      if (r < 7) addr = addr & ~32'(m_size(f3) - 1);
      wd = $urandom;
      er = m_err(we, f3, addr);
      exp_rd = (we || er) ? 32'h0 : m_load(f3, addr);
      lat = er ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
      exec("random", we, f3, addr, wd, exp_rd, er, lat);
    end

    @(negedge clk);
    for (int w = 0; w < 64; w++) check("final_mem_word", 128'(mem[w]), 128'(m_word(w)));

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
